// File: rtl/uart_apb_pkg.sv
// Shared types and constants for the UART APB arbiter: FSM state encoding,
// APB field widths and the latched command record.
package uart_apb_pkg;

   localparam int APB_ADDR_W = 12;
   localparam int APB_DATA_W = 32;
   localparam int APB_STRB_W = 4;

   typedef enum logic [1:0] {
      IDLE,
      SETUP,
      ACCESS
   } state_t;

   // One requester's word command as captured at grant time.
   typedef struct packed {
      logic                  wr;
      logic [APB_ADDR_W-1:0] addr;
      logic [APB_DATA_W-1:0] wdata;
      logic [APB_STRB_W-1:0] strb;
   } cmd_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter. The requester granted last has the lowest priority
// at the next arbitration; the search starts at last_gnt+1 and wraps.
module rr_arbiter #(
   parameter int N_REQ = 2,
   parameter int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [N_REQ-1:0] req,
   input  logic             gnt_en,
   output logic [N_REQ-1:0] gnt,
   output logic [IDX_W-1:0] gnt_idx,
   output logic             gnt_valid
);

   logic [IDX_W-1:0] last_gnt;
   logic [IDX_W-1:0] hi_idx;
   logic [IDX_W-1:0] lo_idx;
   logic             hi_valid;

   // Pick the lowest requester above last_gnt, else the lowest overall.
   always_comb begin
      // NOTE: every signal written here gets a default first, so no path leaves a latch.
      hi_valid  = 1'b0;
      hi_idx    = '0;
      gnt_valid = 1'b0;
      lo_idx    = '0;
      gnt       = '0;
      // Scan downwards so the last hit is the lowest index.
      for (int k = N_REQ - 1; k >= 0; k--) begin
         if (req[k]) begin
            gnt_valid = 1'b1;
            lo_idx    = IDX_W'(k);
            if (k > int'(last_gnt)) begin
               hi_valid = 1'b1;
               hi_idx   = IDX_W'(k);
            end
         end
      end
      gnt_idx = hi_valid ? hi_idx : lo_idx;
      if (gnt_valid) begin
         gnt[gnt_idx] = 1'b1;
      end
   end

   // Move the round-robin pointer to the winner whenever a grant is taken.
   always_ff @(posedge clk) begin
      // NOTE: non-blocking updates keep every register reading pre-edge values, independent of block order.
      if (reset) begin
         last_gnt <= IDX_W'(N_REQ - 1);
      end else if (gnt_en && gnt_valid) begin
         last_gnt <= gnt_idx;
      end
   end

endmodule

// File: rtl/uart_apb_arbiter.sv
// Shares one UART APB slave port between N_REQ requesters: round-robin
// grant, APB SETUP/ACCESS sequencing, registered completion and a wait
// timeout that aborts a stalled access.
module uart_apb_arbiter
   import uart_apb_pkg::*;
#(
   parameter int N_REQ       = 2,
   parameter int TIMEOUT_CYC = 16
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [N_REQ-1:0]              req_i,
   input  logic [N_REQ-1:0]              wr_i,
   input  logic [N_REQ*APB_ADDR_W-1:0]   addr_i,
   input  logic [N_REQ*APB_DATA_W-1:0]   wdata_i,
   input  logic [N_REQ*APB_STRB_W-1:0]   strb_i,
   output logic [N_REQ-1:0]              done_o,
   output logic [APB_DATA_W-1:0]         rdata_o,
   output logic                          err_o,
   output logic                          timeout_o,
   output logic                          psel,
   output logic                          penable,
   output logic                          pwrite,
   output logic [APB_ADDR_W-1:0]         paddr,
   output logic [APB_STRB_W-1:0]         pstrb,
   output logic [APB_DATA_W-1:0]         pwdata,
   input  logic                          pready,
   input  logic                          pslverr,
   input  logic [APB_DATA_W-1:0]         prdata
);

   localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam int CNT_W = $clog2(TIMEOUT_CYC);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

   state_t           state;
   cmd_t             cmd_in [N_REQ];
   cmd_t             cmd_sel;
   cmd_t             cmd_q;
   logic [N_REQ-1:0] gnt;
   logic [N_REQ-1:0] gnt_q;
   logic [IDX_W-1:0] gnt_idx;
   logic             gnt_valid;
   logic             gnt_en;
   logic [CNT_W-1:0] cnt;

   // Unpack the flat request buses; strobes are zeroed for reads here so
   // pstrb is already clean when the command is latched.
   for (genvar k = 0; k < N_REQ; k++) begin : g_unpack
      assign cmd_in[k] = '{
         wr:    wr_i[k],
         addr:  addr_i[k*APB_ADDR_W +: APB_ADDR_W],
         wdata: wdata_i[k*APB_DATA_W +: APB_DATA_W],
         strb:  wr_i[k] ? strb_i[k*APB_STRB_W +: APB_STRB_W] : {APB_STRB_W{1'b0}}
      };
   end

   assign cmd_sel = cmd_in[gnt_idx];

   // Arbitrate only in a genuine IDLE cycle: the done cycle is also IDLE
   // but its requester may still hold req, so it must not win again.
   assign gnt_en = (state == IDLE) && (done_o == '0);

   rr_arbiter #(
      .N_REQ (N_REQ),
      .IDX_W (IDX_W)
   ) u_rr_arbiter (
      .clk       (clk),
      .reset     (reset),
      .req       (req_i),
      .gnt_en    (gnt_en),
      .gnt       (gnt),
      .gnt_idx   (gnt_idx),
      .gnt_valid (gnt_valid)
   );

   assign pwrite = cmd_q.wr;
   assign paddr  = cmd_q.addr;
   assign pstrb  = cmd_q.strb;
   assign pwdata = cmd_q.wdata;

   // Transfer sequencer: grant/latch, SETUP, ACCESS with wait counting,
   // then a one-cycle registered completion pulse.
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         cmd_q     <= '0;
         gnt_q     <= '0;
         cnt       <= '0;
         psel      <= 1'b0;
         penable   <= 1'b0;
         done_o    <= '0;
         rdata_o   <= '0;
         err_o     <= 1'b0;
         timeout_o <= 1'b0;
      end else begin
         done_o    <= '0;
         rdata_o   <= '0;
         err_o     <= 1'b0;
         timeout_o <= 1'b0;
         case (state)
            IDLE: begin
               if (gnt_en && gnt_valid) begin
                  cmd_q <= cmd_sel;
                  gnt_q <= gnt;
                  psel  <= 1'b1;
                  state <= SETUP;
               end
            end
            SETUP: begin
               penable <= 1'b1;
               state   <= ACCESS;
            end
            ACCESS: begin
               if (pready) begin
                  done_o  <= gnt_q;
                  rdata_o <= cmd_q.wr ? '0 : prdata;
                  err_o   <= pslverr;
                  psel    <= 1'b0;
                  penable <= 1'b0;
                  cnt     <= '0;
                  state   <= IDLE;
               end else if (cnt == CNT_LAST) begin
                  done_o    <= gnt_q;
                  err_o     <= 1'b1;
                  timeout_o <= 1'b1;
                  psel      <= 1'b0;
                  penable   <= 1'b0;
                  cnt       <= '0;
                  state     <= IDLE;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_apb_arbiter.sv
// Bench for uart_apb_arbiter: directed vector table, hand-written round-robin
// and reset-abort sequences, then randomized traffic against a reference model.
module tb_uart_apb_arbiter;

   localparam int NR = 3;
   localparam int TO = 16;

   logic              clk = 1'b0;
   logic              reset;
   logic [NR-1:0]     req_i;
   logic [NR-1:0]     wr_i;
   logic [NR*12-1:0]  addr_i;
   logic [NR*32-1:0]  wdata_i;
   logic [NR*4-1:0]   strb_i;
   logic [NR-1:0]     done_o;
   logic [31:0]       rdata_o;
   logic              err_o;
   logic              timeout_o;
   logic              psel;
   logic              penable;
   logic              pwrite;
   logic [11:0]       paddr;
   logic [3:0]        pstrb;
   logic [31:0]       pwdata;
   logic              pready;
   logic              pslverr;
   logic [31:0]       prdata;

   int checks   = 0;
   int failures = 0;

   uart_apb_arbiter #(
      .N_REQ       (NR),
      .TIMEOUT_CYC (TO)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .req_i     (req_i),
      .wr_i      (wr_i),
      .addr_i    (addr_i),
      .wdata_i   (wdata_i),
      .strb_i    (strb_i),
      .done_o    (done_o),
      .rdata_o   (rdata_o),
      .err_o     (err_o),
      .timeout_o (timeout_o),
      .psel      (psel),
      .penable   (penable),
      .pwrite    (pwrite),
      .paddr     (paddr),
      .pstrb     (pstrb),
      .pwdata    (pwdata),
      .pready    (pready),
      .pslverr   (pslverr),
      .prdata    (prdata)
   );

   always #5 clk = ~clk;

   typedef struct {
      int            k;
      logic          wr;
      logic [11:0]   addr;
      logic [31:0]   wdata;
      logic [3:0]    strb;
      int            waits;
      logic          slverr;
      logic [31:0]   prd;
      logic [NR-1:0] exp_done;
      logic [31:0]   exp_rdata;
      logic          exp_err;
      logic          exp_to;
      logic [3:0]    exp_pstrb;
   } vec_t;

   // Reference-model copy of each requester's outstanding payload.
   logic        m_wr    [NR];
   logic [11:0] m_addr  [NR];
   logic [31:0] m_wdata [NR];
   logic [3:0]  m_strb  [NR];

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // All sampling and driving happens on the falling edge.
   task automatic step();
      @(negedge clk);
   endtask

   task automatic set_payload(input int k, input logic wr, input logic [11:0] addr,
                              input logic [31:0] wdata, input logic [3:0] strb);
      wr_i[k]              = wr;
      addr_i[k*12 +: 12]   = addr;
      wdata_i[k*32 +: 32]  = wdata;
      strb_i[k*4 +: 4]     = strb;
   endtask

   task automatic do_reset();
      reset   = 1'b1;
      req_i   = '0;
      pready  = 1'b0;
      pslverr = 1'b0;
      prdata  = '0;
      repeat (2) step();
      check("reset_outputs",
            128'({done_o, rdata_o, err_o, timeout_o, psel, penable, pwrite, paddr, pstrb, pwdata}),
            128'(0));
      reset = 1'b0;
   endtask

   // One complete transfer. Entered at a falling edge whose following rising
   // edge is a grant edge; returns at the falling edge of the cycle after done.
   task automatic xfer(input int k, input logic [48:0] exp_cmd, input int waits,
                       input logic slverr, input logic [31:0] rd,
                       input logic [NR-1:0] exp_done, input logic [31:0] exp_rdata,
                       input logic exp_err, input logic exp_to,
                       input bit scramble, input bit drop_early);
      step();
      check("setup_bus", 128'({psel, penable, pwrite, paddr, pstrb, pwdata}), 128'({2'b10, exp_cmd}));
      check("setup_quiet", 128'({done_o, err_o, timeout_o}), 128'(0));
      // Slave responses during SETUP must be ignored.
      pready  = 1'b1;
      pslverr = 1'b1;
      prdata  = $urandom;
      if (scramble) begin
         set_payload(k, 1'($urandom), 12'($urandom), $urandom, 4'($urandom));
      end
      if (drop_early) begin
         req_i[k] = 1'b0;
      end
      for (int i = 0; i < TO; i++) begin
         step();
         check("access_bus", 128'({psel, penable, pwrite, paddr, pstrb, pwdata}), 128'({2'b11, exp_cmd}));
         check("access_quiet", 128'({done_o, err_o, timeout_o}), 128'(0));
         if (i == waits) begin
            pready  = 1'b1;
            pslverr = slverr;
            prdata  = rd;
            break;
         end
         pready  = 1'b0;
         pslverr = 1'($urandom);
         prdata  = $urandom;
      end
      step();
      pready  = 1'b0;
      pslverr = 1'b0;
      prdata  = '0;
      check("done_pulse", 128'(done_o), 128'(exp_done));
      check("done_rdata", 128'(rdata_o), 128'(exp_rdata));
      check("done_err_to", 128'({err_o, timeout_o}), 128'({exp_err, exp_to}));
      check("done_bus_idle", 128'({psel, penable}), 128'(0));
      // req is still high through the done cycle; it must not be re-granted.
      step();
      check("after_done", 128'({done_o, rdata_o, err_o, timeout_o, psel, penable}), 128'(0));
      req_i[k] = 1'b0;
   endtask

   task automatic raise(input int j);
      m_wr[j]    = 1'($urandom);
      m_addr[j]  = 12'($urandom);
      m_wdata[j] = $urandom;
      m_strb[j]  = 4'($urandom);
      set_payload(j, m_wr[j], m_addr[j], m_wdata[j], m_strb[j]);
      req_i[j] = 1'b1;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got no end of test expected finish before time limit");
      $fatal(1, "watchdog expired");
   end

   initial begin
      vec_t          vecs [7];
      int            rr_order [4];
      logic [NR-1:0] rr_done [4];
      logic [48:0]   rr_cmd [2];
      int            k;
      int            waits;
      int            r;
      logic          slverr;
      logic          to;
      logic [31:0]   rd;
      int            model_ptr;

      //            k  wr  addr     wdata          strb  waits slverr prd            done    rdata          err   to    pstrb
      vecs[0] = '{0, 1'b1, 12'h004, 32'h0000_00A5, 4'h1, 0,  1'b0, 32'hFFFF_FFFF, 3'b001, 32'h0,         1'b0, 1'b0, 4'h1};
      vecs[1] = '{1, 1'b0, 12'h008, 32'h5555_0000, 4'hF, 2,  1'b0, 32'h0000_1234, 3'b010, 32'h0000_1234, 1'b0, 1'b0, 4'h0};
      vecs[2] = '{0, 1'b1, 12'hFFC, 32'h0000_0BAD, 4'h3, 0,  1'b1, 32'h0,         3'b001, 32'h0,         1'b1, 1'b0, 4'h3};
      vecs[3] = '{0, 1'b0, 12'h00C, 32'h0,         4'h0, 99, 1'b0, 32'h0000_CAFE, 3'b001, 32'h0,         1'b1, 1'b1, 4'h0};
      vecs[4] = '{1, 1'b0, 12'h010, 32'h0,         4'h6, 15, 1'b0, 32'hDEAD_BEEF, 3'b010, 32'hDEAD_BEEF, 1'b0, 1'b0, 4'h0};
      vecs[5] = '{1, 1'b0, 12'h020, 32'h0,         4'h0, 1,  1'b1, 32'h0000_0077, 3'b010, 32'h0000_0077, 1'b1, 1'b0, 4'h0};
      vecs[6] = '{0, 1'b1, 12'h7F0, 32'hFFFF_FFFF, 4'hF, 3,  1'b0, 32'h1357_9BDF, 3'b001, 32'h0,         1'b0, 1'b0, 4'hF};

      rr_order = '{0, 1, 0, 1};
      rr_done  = '{3'b001, 3'b010, 3'b001, 3'b010};
      rr_cmd   = '{{1'b1, 12'h100, 4'h3, 32'hAAAA_0000}, {1'b1, 12'h200, 4'hC, 32'hBBBB_0000}};

      reset   = 1'b1;
      req_i   = '0;
      wr_i    = '0;
      addr_i  = '0;
      wdata_i = '0;
      strb_i  = '0;
      pready  = 1'b0;
      pslverr = 1'b0;
      prdata  = '0;
      do_reset();

      // Directed single-requester transfers.
      for (int v = 0; v < 7; v++) begin
         set_payload(vecs[v].k, vecs[v].wr, vecs[v].addr, vecs[v].wdata, vecs[v].strb);
         req_i = '0;
         req_i[vecs[v].k] = 1'b1;
         xfer(vecs[v].k, {vecs[v].wr, vecs[v].addr, vecs[v].exp_pstrb, vecs[v].wdata},
              vecs[v].waits, vecs[v].slverr, vecs[v].prd, vecs[v].exp_done,
              vecs[v].exp_rdata, vecs[v].exp_err, vecs[v].exp_to, 1'b1, 1'b0);
      end

      // Round-robin with both requesters permanently requesting.
      do_reset();
      set_payload(0, 1'b1, 12'h100, 32'hAAAA_0000, 4'h3);
      set_payload(1, 1'b1, 12'h200, 32'hBBBB_0000, 4'hC);
      req_i = 3'b011;
      for (int n = 0; n < 4; n++) begin
         xfer(rr_order[n], rr_cmd[rr_order[n]], 1, 1'b0, 32'h0, rr_done[n], 32'h0,
              1'b0, 1'b0, 1'b0, 1'b0);
         req_i[rr_order[n]] = 1'b1;
      end

      // Reset during ACCESS aborts silently; requester 0 wins first afterwards.
      do_reset();
      set_payload(1, 1'b1, 12'h0AC, 32'h1111_2222, 4'hF);
      req_i = 3'b010;
      step();
      check("mid_setup", 128'({psel, penable}), 128'(2'b10));
      step();
      check("mid_access", 128'({psel, penable}), 128'(2'b11));
      reset = 1'b1;
      step();
      check("mid_reset", 128'({psel, penable, done_o, err_o, timeout_o}), 128'(0));
      reset = 1'b0;
      set_payload(0, 1'b0, 12'h040, 32'h0, 4'h0);
      req_i = 3'b011;
      xfer(0, {1'b0, 12'h040, 4'h0, 32'h0}, 0, 1'b0, 32'h0000_ABCD, 3'b001, 32'h0000_ABCD,
           1'b0, 1'b0, 1'b0, 1'b0);

      // Randomized traffic against the reference model.
      do_reset();
      model_ptr = NR - 1;
      for (int n = 0; n < 150; n++) begin
         for (int j = 0; j < NR; j++) begin
            if (!req_i[j] && ($urandom_range(0, 1) == 1)) raise(j);
         end
         if (req_i == '0) raise(int'($urandom_range(0, NR - 1)));
         k = -1;
         for (int s = 1; s <= NR; s++) begin
            if (k < 0 && req_i[(model_ptr + s) % NR]) k = (model_ptr + s) % NR;
         end
         model_ptr = k;
         r = int'($urandom_range(0, 9));
         if (r == 0)      waits = TO + 3;
         else if (r == 1) waits = TO - 1;
         else             waits = int'($urandom_range(0, 3));
         slverr = 1'($urandom);
         rd     = $urandom;
         to     = (waits >= TO);
         xfer(k, {m_wr[k], m_addr[k], (m_wr[k] ? m_strb[k] : 4'h0), m_wdata[k]},
              waits, slverr, rd, NR'(1 << k),
              (to || m_wr[k]) ? 32'h0 : rd, to ? 1'b1 : slverr, to,
              ($urandom_range(0, 1) == 1), ($urandom_range(0, 3) == 0));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
